// File: rtl/dac_spi_writer.sv
// SPI master for the LTC2624 quad DAC on a shared SPI bus: serialises one
// 32-bit command word per START, captures the echoed word, keeps other devices off the bus.
module dac_spi_writer #(
  parameter int CLK_DIV = 2
) (
  input  logic        CLK_IN,
  input  logic        RST_N,
  input  logic        START,
  input  logic [3:0]  CMD,
  input  logic [3:0]  ADDR,
  input  logic [11:0] VALUE,
  input  logic        SPI_MISO,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] RX_WORD,
  output logic        SPI_MOSI,
  output logic        SPI_SCK,
  output logic        DAC_CS,
  output logic        DAC_CLR,
  output logic        AMP_CS,
  output logic        SF_CE0,
  output logic        SPI_SS_B,
  output logic        FPGA_INIT_B,
  output logic        AD_CONV
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, CSHI} state_t;

  state_t        state_reg, state_next;
  logic [DW-1:0] div_reg, div_next;
  logic [5:0]    bit_reg, bit_next;
  logic [31:0]   tx_reg, tx_next;
  logic [31:0]   rx_reg, rx_next;
  logic [31:0]   rx_word_reg, rx_word_next;
  logic          sck_reg, sck_next;
  logic          mosi_reg, mosi_next;
  logic          cs_reg, cs_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          clr_reg;
  logic          tick;
  logic [31:0]   word;

  assign word = {8'h00, CMD, ADDR, VALUE, 4'h0};
  assign tick = (div_reg == DW'(CLK_DIV - 1));

  always_comb begin
    state_next   = state_reg;
    div_next     = div_reg;
    bit_next     = bit_reg;
    tx_next      = tx_reg;
    rx_next      = rx_reg;
    rx_word_next = rx_word_reg;
    sck_next     = sck_reg;
    mosi_next    = mosi_reg;
    cs_next      = cs_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;

    // Divider free-runs outside IDLE and wraps on each tick.
    if (state_reg == IDLE) begin
      div_next = '0;
    end else if (tick) begin
      div_next = '0;
    end else begin
      div_next = div_reg + 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (START) begin
          tx_next    = word;
          mosi_next  = word[31];
          cs_next    = 1'b0;
          busy_next  = 1'b1;
          bit_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!sck_reg) begin
            sck_next = 1'b1;
            rx_next  = {rx_reg[30:0], SPI_MISO};
            bit_next = bit_reg + 6'd1;
          end else begin
            sck_next = 1'b0;
            if (bit_reg == 6'd32) begin
              cs_next    = 1'b1;
              mosi_next  = 1'b0;
              state_next = CSHI;
            end else begin
              tx_next   = {tx_reg[30:0], 1'b0};
              mosi_next = tx_reg[30];
            end
          end
        end
      end
      CSHI: begin
        // One full tick of CS high before reporting completion.
        if (tick) begin
          rx_word_next = rx_reg;
          done_next    = 1'b1;
          busy_next    = 1'b0;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state_reg   <= IDLE;
      div_reg     <= '0;
      bit_reg     <= '0;
      tx_reg      <= '0;
      rx_reg      <= '0;
      rx_word_reg <= '0;
      sck_reg     <= 1'b0;
      mosi_reg    <= 1'b0;
      cs_reg      <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      clr_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      div_reg     <= div_next;
      bit_reg     <= bit_next;
      tx_reg      <= tx_next;
      rx_reg      <= rx_next;
      rx_word_reg <= rx_word_next;
      sck_reg     <= sck_next;
      mosi_reg    <= mosi_next;
      cs_reg      <= cs_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      clr_reg     <= 1'b1;
    end
  end

  assign BUSY        = busy_reg;
  assign DONE        = done_reg;
  assign RX_WORD     = rx_word_reg;
  assign SPI_MOSI    = mosi_reg;
  assign SPI_SCK     = sck_reg;
  assign DAC_CS      = cs_reg;
  assign DAC_CLR     = clr_reg;
  assign AMP_CS      = 1'b1;
  assign SF_CE0      = 1'b1;
  assign SPI_SS_B    = 1'b1;
  assign FPGA_INIT_B = 1'b1;
  assign AD_CONV     = 1'b0;

endmodule
